// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: camera RGB565 byte stream -> RGB444 frame buffer writer.
// Accepts two bytes per pixel (high byte first), repacks the pixel to 12 bits and
// issues one registered write per kept pixel. It also reports frame completion
// and line/frame framing errors.
// Optional build macro FRAME_BUFFER_WRITER_DECIMATE_EN: the source is twice the
// buffer size in both directions, and only even source rows and columns are kept.
//
// state    | meaning
// ---------|--------------------------------------------------------------
// WAIT_SOF | dropping bytes until a byte with Sof is accepted
// HIGH     | expecting the high byte of the next pixel
// LOW      | high byte latched; expecting the low byte
// DONE     | last buffer line finished; FrameDone pulse is issued
module frame_buffer_writer #(
    parameter int BUF_HRES = 320,
    parameter int BUF_VRES = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              piul1Clock,
    input  logic              piul1Reset,
    input  logic              piul1Valid,
    output logic              poul1Ready,
    input  logic [7:0]        piul8Data,
    input  logic              piul1Sof,
    input  logic              piul1Eol,
    output logic              poul1WEnable,
    output logic [ADDR_W-1:0] poul17WAddr,
    output logic [11:0]       poul12WData,
    output logic              poul1FrameDone,
    output logic              poul1LineError,
    output logic              poul1FrameError
);

`ifdef FRAME_BUFFER_WRITER_DECIMATE_EN
    localparam int SRC_HRES = 2 * BUF_HRES;
`else
    localparam int SRC_HRES = BUF_HRES;
`endif

    localparam logic [9:0]        SRC_HRES_C = 10'(SRC_HRES);
    localparam logic [8:0]        VRES_C     = 9'(BUF_VRES);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(BUF_HRES);

    typedef enum logic [1:0] {WAIT_SOF, HIGH, LOW, DONE} state_t;

    state_t            state_q, state_d;
    logic              ready_q;
    logic [7:0]        hi_q, hi_d;
    logic [9:0]        col_q, col_d;
    logic [8:0]        row_q, row_d;
    logic [8:0]        kept_row_q, kept_row_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [11:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;

    logic              accept, sof, eol;
    logic              row_kept, col_even;
    logic              start_frame, end_line;
    logic [9:0]        col_inc;
    logic [11:0]       pixel;

    assign accept = piul1Valid & ready_q;
    assign sof    = accept & piul1Sof;
    // Sof wins over Eol on the same byte.
    assign eol    = accept & piul1Eol & ~piul1Sof;

`ifdef FRAME_BUFFER_WRITER_DECIMATE_EN
    assign row_kept = ~row_q[0];
    assign col_even = ~col_q[0];
`else
    assign row_kept = 1'b1;
    assign col_even = 1'b1;
`endif

    // Saturate so an overlong line can never wrap back into the writable range.
    assign col_inc = (&col_q) ? col_q : col_q + 10'd1;
    assign pixel   = {hi_q[7:4], hi_q[2:0], piul8Data[7], piul8Data[4:1]};

    // Ready comes up on the first clock after reset and never drops.
    always_ff @(posedge piul1Clock or posedge piul1Reset) begin
        if (piul1Reset) ready_q <= 1'b0;
        else            ready_q <= 1'b1;
    end

    // State, counters and registered write-port / status outputs.
    always_ff @(posedge piul1Clock or posedge piul1Reset) begin
        if (piul1Reset) begin
            state_q     <= WAIT_SOF;
            hi_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            kept_row_q  <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            col_q       <= col_d;
            row_q       <= row_d;
            kept_row_q  <= kept_row_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state decode, pixel write generation and line/frame bookkeeping.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        col_d       = col_q;
        row_d       = row_q;
        kept_row_d  = kept_row_q;
        base_d      = base_q;
        addr_d      = addr_q;
        wen_d       = 1'b0;
        waddr_d     = '0;
        wdata_d     = '0;
        done_d      = 1'b0;
        line_err_d  = line_err_q;
        frame_err_d = 1'b0;
        start_frame = 1'b0;
        end_line    = 1'b0;

        case (state_q)
            WAIT_SOF: begin
                if (sof) start_frame = 1'b1;
            end
            HIGH: begin
                if (sof) begin
                    start_frame = 1'b1;
                    frame_err_d = 1'b1;
                end else if (eol) begin
                    // Odd byte count: the dangling high byte is dropped.
                    line_err_d = 1'b1;
                    end_line   = 1'b1;
                end else if (accept) begin
                    hi_d    = piul8Data;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (sof) begin
                    start_frame = 1'b1;
                    frame_err_d = 1'b1;
                end else if (accept) begin
                    state_d = HIGH;
                    col_d   = col_inc;
                    if (col_q >= SRC_HRES_C) begin
                        line_err_d = 1'b1;
                    end else if (row_kept && col_even) begin
                        wen_d   = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = pixel;
                        addr_d  = addr_q + 1'b1;
                    end
                    if (eol) begin
                        end_line = 1'b1;
                        if (col_q < SRC_HRES_C - 10'd1) line_err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = WAIT_SOF;
                if (sof) start_frame = 1'b1;
            end
            default: state_d = WAIT_SOF;
        endcase

        if (start_frame) begin
            state_d    = LOW;
            hi_d       = piul8Data;
            col_d      = '0;
            row_d      = '0;
            kept_row_d = '0;
            base_d     = '0;
            addr_d     = '0;
            line_err_d = 1'b0;
        end

        // A line end always realigns the address to the next buffer row, which
        // also covers short lines; the final row parks the address at 0.
        if (end_line) begin
            col_d = '0;
            row_d = row_q + 9'd1;
            if (row_kept) begin
                kept_row_d = kept_row_q + 9'd1;
                base_d     = base_q + ROW_STEP;
                addr_d     = base_q + ROW_STEP;
                if (kept_row_q == VRES_C - 9'd1) begin
                    state_d = DONE;
                    base_d  = '0;
                    addr_d  = '0;
                end
            end
        end
    end

    assign poul1Ready      = ready_q;
    assign poul1WEnable    = wen_q;
    assign poul17WAddr     = waddr_q;
    assign poul12WData     = wdata_q;
    assign poul1FrameDone  = done_q;
    assign poul1LineError  = line_err_q;
    assign poul1FrameError = frame_err_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Testbench for frame_buffer_writer using a reduced buffer size so that whole
// frames fit in a short run. Expected writes come from a pixel/row arithmetic
// model and are checked by a scoreboard on the write port.
module tb_frame_buffer_writer;

    localparam int HRES = 16;
    localparam int VRES = 12;
    localparam int AW   = 17;
`ifdef FRAME_BUFFER_WRITER_DECIMATE_EN
    localparam int DEC = 2;
`else
    localparam int DEC = 1;
`endif
    localparam int SRC_W = DEC * HRES;
    localparam int SRC_V = DEC * VRES;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid, sof, eol;
    logic [7:0]    data;
    logic          ready, wen, done, lerr, ferr;
    logic [AW-1:0] waddr;
    logic [11:0]   wdata;

    int checks = 0;
    int errors = 0;

    logic [AW+11:0] exp_q[$];
    int  wr_cnt = 0, done_seen = 0, ferr_seen = 0;
    bit  m_active = 0, m_line_err = 0;
    int  m_row = 0, m_kept = 0, m_done = 0, m_ferr = 0;

    frame_buffer_writer #(.BUF_HRES(HRES), .BUF_VRES(VRES), .ADDR_W(AW)) dut (
        .piul1Clock(clk), .piul1Reset(rst), .piul1Valid(valid), .poul1Ready(ready),
        .piul8Data(data), .piul1Sof(sof), .piul1Eol(eol), .poul1WEnable(wen),
        .poul17WAddr(waddr), .poul12WData(wdata), .poul1FrameDone(done),
        .poul1LineError(lerr), .poul1FrameError(ferr)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (!rst) begin
            if (wen) begin
                logic [AW+11:0] e;
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h", waddr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({waddr, wdata} !== e) begin
                        errors++;
                        $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                                 waddr, wdata, e[AW+11:12], e[11:0]);
                    end
                end
            end
            if (done) done_seen++;
            if (ferr) ferr_seen++;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            valid = 1'b0; data = 8'($urandom); sof = 1'($urandom); eol = 1'($urandom);
            @(negedge clk);
        end
        valid = 1'b1; data = d; sof = s; eol = e;
        @(negedge clk);
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
    endtask

    // Sends one source line and updates the reference model from the pixel rules.
    task automatic send_line(input int npix, input bit start_sof, input bit sof_eol,
                             input bit odd_extra, input bit end_line, input int pattern);
        logic [15:0] p;
        logic [11:0] rgb;
        for (int c = 0; c < npix; c++) begin
            bit s;
            s = start_sof && (c == 0);
            case (pattern)
                0:       p = 16'($urandom);
                1:       p = 16'hF81F;
                default: p = 16'(c);
            endcase
            if (s) begin
                if (m_active) m_ferr++;
                m_active = 1; m_row = 0; m_kept = 0; m_line_err = 0;
            end
            if (m_active && c < SRC_W && (DEC == 1 || (c % 2 == 0 && m_row % 2 == 0))) begin
                rgb = {p[15:12], p[10:7], p[4:1]};
                exp_q.push_back({AW'(m_kept * HRES + c / DEC), rgb});
            end
            send_byte(p[15:8], s, s & sof_eol);
            send_byte(p[7:0], 1'b0, end_line && !odd_extra && c == npix - 1);
        end
        if (odd_extra) send_byte(8'($urandom), 1'b0, end_line);
        if (end_line && m_active) begin
            if (npix != SRC_W || odd_extra) m_line_err = 1;
            if (DEC == 1 || m_row % 2 == 0) begin
                m_kept++;
                if (m_kept == VRES) begin
                    m_active = 0;
                    m_done++;
                end
            end
            m_row++;
        end
    endtask

    task automatic send_frame(input int spec_row, input int spec_len, input bit spec_odd,
                              input bit sof_eol, input int pattern);
        for (int r = 0; r < SRC_V; r++)
            send_line((r == spec_row) ? spec_len : SRC_W, r == 0, sof_eol,
                      spec_odd && r == spec_row, 1'b1, pattern);
    endtask

    task automatic test_reset;
        rst = 1'b0; valid = 1'b0; data = 8'h00; sof = 1'b0; eol = 1'b0;
        #2 rst = 1'b1;
        #2;
        checks++;
        if ({ready, wen, waddr, wdata, done, lerr, ferr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {ready, wen, waddr, wdata, done, lerr, ferr});
        end
        @(negedge clk) rst = 1'b0;
        #1 checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL ready_before_clock got %b exp 0", ready); end
        @(posedge clk) #1 checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_clock got %b exp 1", ready); end
        @(negedge clk);
    endtask

    task automatic test_latency;
        send_line(1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if ({wen, waddr} !== {1'b1, AW'(0)}) begin
            errors++;
            $display("FAIL latency got wen=%b addr=%0d exp wen=1 addr=0", wen, waddr);
        end
        @(negedge clk);
        checks++;
        if (wen !== 1'b0) begin errors++; $display("FAIL wen_width got %b exp 0", wen); end
    endtask

    task automatic test_frame(input int pattern, input string name);
        int w0 = wr_cnt;
        send_frame(-1, 0, 1'b0, 1'b0, pattern);
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt - w0 != HRES * VRES) begin
            errors++; $display("FAIL %s_writes got %0d exp %0d", name, wr_cnt - w0, HRES * VRES);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s_pending got %0d exp 0", name, exp_q.size()); end
        checks++;
        if (done_seen != m_done) begin errors++; $display("FAIL %s_done got %0d exp %0d", name, done_seen, m_done); end
        checks++;
        if (ferr_seen != m_ferr) begin errors++; $display("FAIL %s_ferr got %0d exp %0d", name, ferr_seen, m_ferr); end
        checks++;
        if (lerr !== m_line_err) begin errors++; $display("FAIL %s_lerr got %b exp %b", name, lerr, m_line_err); end
    endtask

    task automatic test_line_fault(input int row, input int len, input bit odd, input string name);
        for (int r = 0; r < SRC_V; r++) begin
            send_line((r == row) ? len : SRC_W, r == 0, 1'b0, odd && r == row, 1'b1, 0);
            if (r == row) begin
                checks++;
                if (lerr !== m_line_err || m_line_err != 1) begin
                    errors++; $display("FAIL %s_lerr_set got %b exp 1", name, lerr);
                end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL %s_pending got %0d exp 0", name, exp_q.size()); end
        checks++;
        if (done_seen != m_done) begin errors++; $display("FAIL %s_done got %0d exp %0d", name, done_seen, m_done); end
        checks++;
        if (lerr !== m_line_err) begin errors++; $display("FAIL %s_lerr_end got %b exp %b", name, lerr, m_line_err); end
    endtask

    task automatic test_sof_mid;
        for (int r = 0; r < 10; r++)
            send_line((r == 2) ? SRC_W - 3 : SRC_W, r == 0, 1'b0, 1'b0, 1'b1, 0);
        send_line(SRC_W / 2, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (lerr !== 1'b1) begin errors++; $display("FAIL sofmid_lerr_before got %b exp 1", lerr); end
        send_frame(-1, 0, 1'b0, 1'b1, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (ferr_seen != m_ferr) begin errors++; $display("FAIL sofmid_ferr got %0d exp %0d", ferr_seen, m_ferr); end
        checks++;
        if (lerr !== m_line_err) begin errors++; $display("FAIL sofmid_lerr got %b exp %b", lerr, m_line_err); end
        checks++;
        if (done_seen != m_done) begin errors++; $display("FAIL sofmid_done got %0d exp %0d", done_seen, m_done); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sofmid_pending got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int left = 100;
        int w0;
        send_line(10, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        left -= 10;
        while (left >= SRC_W) begin
            send_line(SRC_W, 1'b0, 1'b0, 1'b0, 1'b1, 0);
            left -= SRC_W;
        end
        send_line(left, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #2 rst = 1'b1;
        #1 checks++;
        if ({ready, wen, waddr, wdata, done, lerr, ferr} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h exp 0", {ready, wen, waddr, wdata, done, lerr, ferr});
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_pending got %0d exp 0", exp_q.size()); end
        exp_q.delete();
        m_active = 0; m_line_err = 0;
        @(negedge clk) rst = 1'b0;
        #1 checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready0 got %b exp 0", ready); end
        @(posedge clk) #1 checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready1 got %b exp 1", ready); end
        @(negedge clk);
        w0 = wr_cnt;
        send_line(SRC_W, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_line(SRC_W, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt != w0) begin errors++; $display("FAIL no_sof_writes got %0d exp 0", wr_cnt - w0); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frame(1, "nominal");
        test_frame(2, "column");
        test_frame(0, "random");
        test_line_fault(5, SRC_W - 3, 1'b0, "short");
        test_line_fault(3, SRC_W - 2, 1'b1, "odd");
        test_line_fault(2, SRC_W + 3, 1'b0, "long");
        test_sof_mid();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Capture-side writer that fills the 320x240 RGB444 frame buffer read by the VGA driver.
- Accepts a synchronous camera byte stream: RGB565, two bytes per pixel, high byte first, with start-of-frame and end-of-line markers.
- Repacks each pixel to RGB444, optionally decimates 640x480 to 320x240, and drives the frame buffer write port (enable/address/data).
- Reports frame completion and malformed-line/frame errors.

Parameters:
- BUF_HRES, 320, buffer width in pixels.
- BUF_VRES, 240, buffer height in lines.
- ADDR_W, 17, buffer address width; must satisfy 2^ADDR_W >= BUF_HRES*BUF_VRES.

Ports:
- piul1Clock  in  1  single clock for stream and write port.
- piul1Reset  in  1  asynchronous, active-high reset.
- piul1Valid  in  1  byte valid.
- poul1Ready  out  1  byte accepted when Valid&Ready.
- piul8Data  in  8  stream byte.
- piul1Sof  in  1  qualifies the accepted byte as the first byte of a frame.
- piul1Eol  in  1  qualifies the accepted byte as the last byte of a line.
- poul1WEnable  out  1  buffer write strobe.
- poul17WAddr  out  ADDR_W  buffer write address.
- poul12WData  out  12  {R[3:0],G[3:0],B[3:0]}.
- poul1FrameDone  out  1  one-cycle pulse after the last buffer line completes.
- poul1LineError  out  1  sticky; cleared by the next accepted Sof.
- poul1FrameError  out  1  one-cycle pulse when Sof arrives mid-frame.

Behaviour:
- Reset, asynchronous: all outputs 0, Ready=0, state WAIT_SOF, counters 0. Ready rises on the first clock after reset deasserts and then stays 1. The block never applies backpressure.
- Byte acceptance is Valid&Ready. Sof and Eol are ignored unless the byte is accepted.
- States:
  - WAIT_SOF: drop accepted bytes until one arrives with Sof. That byte is the high byte; latch it and go to LOW.
  - HIGH: latch the byte and go to LOW. If Eol is set on a high byte, set LineError, discard the partial pixel, end the line, and stay in HIGH.
  - LOW: form the pixel and go to HIGH. If Eol is set, end the line after this pixel.
  - DONE: after BUF_VRES kept lines, pulse FrameDone for one cycle and go to WAIT_SOF.
- Pixel repack from hi/lo bytes:
  - R5 = hi[7:3], G6 = {hi[2:0], lo[7:5]}, B5 = lo[4:0].
  - WData = {R5[4:1], G6[5:2], B5[4:1]}, truncation only, no rounding.
- Counters:
  - Source column counter: 10 bits.
  - Source row counter: 9 bits.
  - Buffer address register: ADDR_W bits, 0 at frame start; increments by 1 per kept pixel.
- Write timing: WEnable, WAddr and WData are registered and asserted for exactly one cycle, on the cycle after the low byte is accepted. Latency is 1 cycle.
- Line end:
  - Column counter resets to 0; row counter increments.
  - If the line kept fewer than BUF_HRES pixels, set LineError and advance the address to the start of the next buffer row: (kept_row+1)*BUF_HRES.
  - Kept pixels beyond BUF_HRES in a line are not written; set LineError.
- Sof accepted in any state other than WAIT_SOF or DONE:
  - Pulse FrameError and restart the frame at address 0 with this byte as the high byte.
  - Clear LineError.
  - No FrameDone is emitted for the aborted frame.
- Frame end: when the kept row count reaches BUF_VRES (on the Eol that completes it), enter DONE. Further bytes are dropped until the next Sof.
- Address never exceeds BUF_HRES*BUF_VRES-1; no wrap within a frame.
- Simultaneous Sof and Eol on one accepted byte: Sof takes priority; Eol is ignored.

Optional Feature:
- Macro FRAME_BUFFER_WRITER_DECIMATE_EN.
- Defined: source is 2*BUF_HRES x 2*BUF_VRES (640x480). Keep only pixels with even source column and even source row. Odd rows still count for Eol/row tracking but produce no writes. Line-length checks apply to the source width of 640.
- Undefined: source is BUF_HRES x BUF_VRES and every pixel is kept.

Test Plan:
- Reset mid-frame (after 100 pixels): all outputs 0 immediately. After release, Ready=1 on the next clock; bytes without Sof produce no writes.
- Nominal frame (non-decimated): 320x240 pixels with byte pair 0xF8,0x1F (pure R+B) -> 76800 writes, WData=0xF0F, addresses 0..76799 in order, FrameDone pulses once after the last write.
- Decimated frame (macro defined): 640x480 source where pixel value = column -> 76800 writes, buffer row 0 holds the pixels from even source columns; FrameDone once.
- Short line: line 5 ends after 300 pixels -> LineError=1, and the first write of line 6 is at address 6*320=1920.
- Odd byte count: Eol arrives on a high byte -> partial pixel not written, LineError=1, next line starts at the next row boundary.
- Sof during line 10 -> FrameError pulses once, next write at address 0, LineError cleared, no FrameDone for the aborted frame.
